// File: rtl/mf_pkg.sv
// Shared types and constants for the matched-filter load sequencer.
package mf_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int STATE_W            = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE        = 3'd0,
    LOAD_COEFF  = 3'd1,
    GAP         = 3'd2,
    STREAM_DATA = 3'd3,
    FLUSH       = 3'd4,
    DONE        = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mf_stream_forwarder.sv
// One sample source channel: enable, 1-cycle sample register, sample counter, exit/mismatch detection.
// With MF_LOAD_TIMEOUT_EN a count terminal without flag holds the enable and stalls instead of exiting.
module mf_stream_forwarder #(
  parameter int LENGTH     = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 4,
  parameter int IDX_W      = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         flag_i,
  input  logic signed [DATA_WIDTH-1:0] re_i,
  input  logic signed [DATA_WIDTH-1:0] im_i,
  output logic                         enable_o,
  output logic                         valid_o,
  output logic        [IDX_W-1:0]      index_o,
  output logic signed [DATA_WIDTH-1:0] re_o,
  output logic signed [DATA_WIDTH-1:0] im_o,
  output logic                         exit_o,
  output logic                         mismatch_o
);

  logic                         en_q, armed_q, valid_q;
  logic        [CNT_W-1:0]      cnt_q;
  logic        [IDX_W-1:0]      idx_q;
  logic signed [DATA_WIDTH-1:0] re_q, im_q;
  logic                         terminal, capture;

  assign terminal = (cnt_q == CNT_W'(LENGTH - 1));

`ifdef MF_LOAD_TIMEOUT_EN
  logic stall_q;

  assign capture = armed_q && !stall_q;
  assign exit_o  = armed_q && flag_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             stall_q <= 1'b0;
    else if (abort_i || start_i || exit_o) stall_q <= 1'b0;
    else if (capture && terminal && !flag_i) stall_q <= 1'b1;
  end
`else
  assign capture = armed_q;
  assign exit_o  = armed_q && (flag_i || terminal);
`endif

  // Flag and count terminal must coincide; either one alone is a length mismatch.
  assign mismatch_o = capture && (flag_i != terminal);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (abort_i) begin
        en_q    <= 1'b0;
        armed_q <= 1'b0;
      end else if (start_i) begin
        en_q    <= 1'b1;
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        armed_q <= en_q;
        if (capture) begin
          valid_q <= 1'b1;
          re_q    <= re_i;
          im_q    <= im_i;
          idx_q   <= cnt_q[IDX_W-1:0];
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        if (exit_o) begin
          en_q    <= 1'b0;
          armed_q <= 1'b0;
        end
      end
    end
  end

  assign enable_o = en_q;
  assign valid_o  = valid_q;
  assign index_o  = idx_q;
  assign re_o     = re_q;
  assign im_o     = im_q;

endmodule

// File: rtl/mf_load_sequencer.sv
// Matched-filter load sequencer: coefficient load, gap, data stream, flush, done.
// Optional watchdog and timeout port enabled by MF_LOAD_TIMEOUT_EN.
module mf_load_sequencer
  import mf_pkg::*;
#(
  parameter int COEFF_LENGTH = 800,
  parameter int DATA_LENGTH  = 33000,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int GAP_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                coeffFinishedFlag,
  input  logic signed [DATA_WIDTH-1:0]        coeffRe,
  input  logic signed [DATA_WIDTH-1:0]        coeffIm,
  input  logic                                dataFinishedFlag,
  input  logic signed [DATA_WIDTH-1:0]        dataRe,
  input  logic signed [DATA_WIDTH-1:0]        dataIm,
  output logic                                coeffEnable,
  output logic                                dataEnable,
  output logic                                mfCoeffLoad,
  output logic        [$clog2(COEFF_LENGTH)-1:0] mfCoeffIndex,
  output logic signed [DATA_WIDTH-1:0]        mfCoeffRe,
  output logic signed [DATA_WIDTH-1:0]        mfCoeffIm,
  output logic                                mfDataValid,
  output logic signed [DATA_WIDTH-1:0]        mfDataRe,
  output logic signed [DATA_WIDTH-1:0]        mfDataIm,
  output logic                                busy,
  output logic                                done,
`ifdef MF_LOAD_TIMEOUT_EN
  output logic                                timeout,
`endif
  output logic                                error
);

  localparam int CNT_W = $clog2(max_int(COEFF_LENGTH, DATA_LENGTH)) + 1;
  localparam int IDX_W = $clog2(COEFF_LENGTH);
  localparam int TMR_W = $clog2(max_int(GAP_CYCLES, FLUSH_CYCLES)) + 1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               error_q, error_d;
  logic               coeff_start, data_start, abort;
  logic               coeff_exit, coeff_mis, data_exit, data_mis;
  logic [0:0]         data_idx_unused;

  mf_stream_forwarder #(
    .LENGTH(COEFF_LENGTH), .DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) u_coeff (
    .clock(clock), .reset(reset), .start_i(coeff_start), .abort_i(abort),
    .flag_i(coeffFinishedFlag), .re_i(coeffRe), .im_i(coeffIm),
    .enable_o(coeffEnable), .valid_o(mfCoeffLoad), .index_o(mfCoeffIndex),
    .re_o(mfCoeffRe), .im_o(mfCoeffIm), .exit_o(coeff_exit), .mismatch_o(coeff_mis)
  );

  mf_stream_forwarder #(
    .LENGTH(DATA_LENGTH), .DATA_WIDTH(DATA_WIDTH), .CNT_W(CNT_W), .IDX_W(1)
  ) u_data (
    .clock(clock), .reset(reset), .start_i(data_start), .abort_i(abort),
    .flag_i(dataFinishedFlag), .re_i(dataRe), .im_i(dataIm),
    .enable_o(dataEnable), .valid_o(mfDataValid), .index_o(data_idx_unused),
    .re_o(mfDataRe), .im_o(mfDataIm), .exit_o(data_exit), .mismatch_o(data_mis)
  );

`ifdef MF_LOAD_TIMEOUT_EN
  localparam int WD_W = CNT_W + 1;

  logic [WD_W-1:0] wd_q;
  logic            timeout_q, timeout_d, wd_fire;

  // wd_q is 0 in the first cycle of a state, so the timeout flag shows on cycle LENGTH+8.
  assign wd_fire = ((state_q == LOAD_COEFF)  && (wd_q == WD_W'(COEFF_LENGTH + 6))) ||
                   ((state_q == STREAM_DATA) && (wd_q == WD_W'(DATA_LENGTH + 6)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= (state_d == state_q) ? wd_q + WD_W'(1) : '0;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    error_d     = error_q;
    coeff_start = 1'b0;
    data_start  = 1'b0;
    abort       = 1'b0;
`ifdef MF_LOAD_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    if (coeff_mis || data_mis) error_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD_COEFF;
          coeff_start = 1'b1;
          error_d     = 1'b0;
`ifdef MF_LOAD_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      LOAD_COEFF: begin
        if (coeff_exit) begin
          state_d = GAP;
          timer_d = TMR_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d    = STREAM_DATA;
          data_start = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      STREAM_DATA: begin
        if (data_exit) begin
          state_d = FLUSH;
          timer_d = TMR_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (timer_q == '0) state_d = DONE;
        else               timer_d = timer_q - TMR_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MF_LOAD_TIMEOUT_EN
    if (wd_fire) begin
      state_d   = IDLE;
      abort     = 1'b1;
      error_d   = 1'b1;
      timeout_d = 1'b1;
    end
`endif
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign error = error_q;

endmodule

// File: tb/tb_mf_load_sequencer.sv
// Directed bench for mf_load_sequencer (COEFF_LENGTH=8, DATA_LENGTH=20); covers MF_LOAD_TIMEOUT_EN when defined.
module tb_mf_load_sequencer;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               coeffFinishedFlag = 1'b0;
  logic signed [15:0] coeffRe = '0, coeffIm = '0;
  logic               dataFinishedFlag = 1'b0;
  logic signed [15:0] dataRe = '0, dataIm = '0;
  logic               coeffEnable, dataEnable, mfCoeffLoad, mfDataValid, busy, done, error;
  logic        [2:0]  mfCoeffIndex;
  logic signed [15:0] mfCoeffRe, mfCoeffIm, mfDataRe, mfDataIm;
`ifdef MF_LOAD_TIMEOUT_EN
  logic               timeout;
`endif

  int checks = 0;
  int failures = 0;
  int coeff_flag_at = 7;
  int data_flag_at = 19;

  mf_load_sequencer #(
    .COEFF_LENGTH(8), .DATA_LENGTH(20), .DATA_WIDTH(16), .GAP_CYCLES(4), .FLUSH_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .coeffFinishedFlag(coeffFinishedFlag), .coeffRe(coeffRe), .coeffIm(coeffIm),
    .dataFinishedFlag(dataFinishedFlag), .dataRe(dataRe), .dataIm(dataIm),
    .coeffEnable(coeffEnable), .dataEnable(dataEnable),
    .mfCoeffLoad(mfCoeffLoad), .mfCoeffIndex(mfCoeffIndex),
    .mfCoeffRe(mfCoeffRe), .mfCoeffIm(mfCoeffIm),
    .mfDataValid(mfDataValid), .mfDataRe(mfDataRe), .mfDataIm(mfDataIm),
    .busy(busy), .done(done),
`ifdef MF_LOAD_TIMEOUT_EN
    .timeout(timeout),
`endif
    .error(error)
  );

  always #10 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1);
  end

  // Ideal sources: one cycle after seeing enable, present a sample per cycle.
  // Coeff ramp Re=1000+i, data ramp Re=i; Im is the negation; flag on sample *_flag_at.
  initial begin : sources
    int  cidx, didx;
    bit  ce, de;
    cidx = 0;
    didx = 0;
    forever begin
      @(negedge clock);
      ce = coeffEnable;
      de = dataEnable;
      @(posedge clock);
      #1;
      if (ce) begin
        coeffRe = 16'(1000 + cidx);
        coeffIm = 16'(-(1000 + cidx));
        coeffFinishedFlag = (cidx == coeff_flag_at);
        cidx++;
      end else begin
        cidx = 0; coeffRe = '0; coeffIm = '0; coeffFinishedFlag = 1'b0;
      end
      if (de) begin
        dataRe = 16'(didx);
        dataIm = 16'(-didx);
        dataFinishedFlag = (didx == data_flag_at);
        didx++;
      end else begin
        didx = 0; dataRe = '0; dataIm = '0; dataFinishedFlag = 1'b0;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int c_at;
    int d_at;
    bit poke;
    int e_load;
    int e_valid;
    int e_err;
    int e_done;
  } vec_t;

  task automatic run(input int vi, input vec_t v);
    int  cyc, n_load, n_valid, n_done, gap, bad, last_v, done_c, de_c, to_c, err0;
    bit  fin, had_ce, had_de;
    logic signed [15:0] pcr, pci, pdr, pdi, er, ei;
    coeff_flag_at = v.c_at;
    data_flag_at  = v.d_at;
    cyc = 0; n_load = 0; n_valid = 0; n_done = 0; gap = 0; bad = 0;
    last_v = -1; done_c = -1; de_c = -1; to_c = -1; err0 = -1;
    fin = 1'b0; had_ce = 1'b0; had_de = 1'b0;
    pcr = '0; pci = '0; pdr = '0; pdi = '0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    while (!fin && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) err0 = int'(error);
      if (mfCoeffLoad) begin
        er = 16'(1000 + n_load);
        ei = 16'(-(1000 + n_load));
        if (mfCoeffRe !== pcr || mfCoeffIm !== pci || mfCoeffRe !== er ||
            mfCoeffIm !== ei || mfCoeffIndex !== 3'(n_load)) bad++;
        n_load++;
      end
      if (mfDataValid) begin
        er = 16'(n_valid);
        ei = 16'(-n_valid);
        if (mfDataRe !== pdr || mfDataIm !== pdi || mfDataRe !== er || mfDataIm !== ei) bad++;
        n_valid++;
        last_v = cyc;
      end
      if (done) begin n_done++; done_c = cyc; end
      if (had_ce && !had_de && !coeffEnable && !dataEnable) gap++;
      if (coeffEnable) had_ce = 1'b1;
      if (dataEnable && !had_de) begin had_de = 1'b1; de_c = cyc; end
`ifdef MF_LOAD_TIMEOUT_EN
      if (timeout && to_c < 0) to_c = cyc;
`endif
      pcr = coeffRe; pci = coeffIm; pdr = dataRe; pdi = dataIm;
      if (v.poke) start = (n_valid >= 5 && n_valid < 8);
      if (!busy) fin = 1'b1;
    end
    start = 1'b0;
    check($sformatf("v%0d_run_ended", vi), fin, 1);
    check($sformatf("v%0d_error_cleared_at_start", vi), err0, 0);
    check($sformatf("v%0d_coeff_loads", vi), n_load, v.e_load);
    check($sformatf("v%0d_data_valids", vi), n_valid, v.e_valid);
    check($sformatf("v%0d_sample_integrity_bad", vi), bad, 0);
    check($sformatf("v%0d_gap_cycles", vi), gap, 4);
    check($sformatf("v%0d_done_pulses", vi), n_done, v.e_done);
    check($sformatf("v%0d_error", vi), error, v.e_err);
    if (v.e_done != 0)
      check($sformatf("v%0d_done_after_last_valid", vi), done_c - last_v, 16);
`ifdef MF_LOAD_TIMEOUT_EN
    check($sformatf("v%0d_timeout_flag", vi), timeout, (v.e_done == 0) ? 1 : 0);
    if (v.e_done == 0)
      check($sformatf("v%0d_timeout_cycle", vi), to_c - de_c + 1, 28);
`endif
    if (v.poke) begin
      n_load = 0;
      repeat (3) begin
        @(negedge clock);
        if (busy) n_load++;
      end
      check($sformatf("v%0d_no_rerun_after_poke", vi), n_load, 0);
    end
  endtask

  vec_t vecs[6];

  initial begin : main
    int cyc;
    int nv;
    vecs[0] = '{c_at: 7, d_at: 19, poke: 1'b0, e_load: 8, e_valid: 20, e_err: 0, e_done: 1};
    vecs[1] = '{c_at: 4, d_at: 19, poke: 1'b0, e_load: 5, e_valid: 20, e_err: 1, e_done: 1};
`ifdef MF_LOAD_TIMEOUT_EN
    vecs[2] = '{c_at: 7, d_at: -1, poke: 1'b0, e_load: 8, e_valid: 20, e_err: 1, e_done: 0};
`else
    vecs[2] = '{c_at: 7, d_at: -1, poke: 1'b0, e_load: 8, e_valid: 20, e_err: 1, e_done: 1};
`endif
    vecs[3] = '{c_at: 7, d_at: 19, poke: 1'b1, e_load: 8, e_valid: 20, e_err: 0, e_done: 1};
    vecs[4] = '{c_at: 0, d_at: 0,  poke: 1'b0, e_load: 1, e_valid: 1,  e_err: 1, e_done: 1};
    vecs[5] = '{c_at: 9, d_at: 19, poke: 1'b0, e_load: 8, e_valid: 20, e_err: 1, e_done: 1};

    repeat (2) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_enables", {coeffEnable, dataEnable}, 0);
    check("reset_strobes", {mfCoeffLoad, mfDataValid}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) run(i, vecs[i]);

    // Reset in the middle of the data stream, with a sticky error pending.
    coeff_flag_at = 4;
    data_flag_at  = 19;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    cyc = 0;
    nv  = 0;
    while (nv < 10 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (mfDataValid) nv++;
    end
    check("rst_reached_sample_10", nv, 10);
    check("rst_pre_error", error, 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_enables", {coeffEnable, dataEnable}, 0);
    check("rst_strobes", {mfCoeffLoad, mfDataValid, done}, 0);
    check("rst_error", error, 0);
    check("rst_coeff_out", {mfCoeffIndex, mfCoeffRe, mfCoeffIm}, 0);
    check("rst_data_out", {mfDataRe, mfDataIm}, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run(6, vecs[0]);

    // start held high: back-to-back runs with a single idle cycle between.
    coeff_flag_at = 7;
    data_flag_at  = 19;
    @(posedge clock); #1 start = 1'b1;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    check("held_first_done", done, 1);
    @(negedge clock);
    check("held_idle_cycle_busy", busy, 0);
    @(negedge clock);
    check("held_rerun_busy", busy, 1);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    check("held_second_run_ended", busy, 0);
    check("held_second_run_error", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mf_load_sequencer.md
Name: mf_load_sequencer

Overview:
- Top-level sequencer for the matched-filter datapath. Drives two sample sources of the setup_MF_coeff type: a coefficient source (DATA_TYPE 1) and an input-data source (DATA_TYPE 2).
- On start it loads COEFF_LENGTH complex coefficients into the matched filter with an index, then streams DATA_LENGTH complex input samples.
- After streaming it waits FLUSH_CYCLES for the filter pipeline to drain, then signals done.

Parameters:
- COEFF_LENGTH, 800: number of coefficient samples to load.
- DATA_LENGTH, 33000: number of input samples to stream.
- DATA_WIDTH, 16: width of each Re/Im sample, signed.
- GAP_CYCLES, 4: idle cycles between end of coefficient load and data enable.
- FLUSH_CYCLES, 16: cycles waited after the last data sample before done.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- coeffFinishedFlag  in  1  coefficient source is high together with its last sample.
- coeffRe, coeffIm  in  DATA_WIDTH  coefficient source samples.
- dataFinishedFlag  in  1  data source is high together with its last sample.
- dataRe, dataIm  in  DATA_WIDTH  data source samples.
- coeffEnable  out  1  enable for the coefficient source.
- dataEnable  out  1  enable for the data source.
- mfCoeffLoad  out  1  coefficient write strobe to the matched filter.
- mfCoeffIndex  out  $clog2(COEFF_LENGTH)  coefficient write address.
- mfCoeffRe, mfCoeffIm  out  DATA_WIDTH  registered coefficient.
- mfDataValid  out  1  input sample valid to the matched filter.
- mfDataRe, mfDataIm  out  DATA_WIDTH  registered input sample.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- error  out  1  sticky length-mismatch flag; cleared by the next accepted start.

Behaviour:
- Reset values: all outputs 0, counters 0, state IDLE. Reset asserted mid-run aborts immediately; both enables drop asynchronously.
- Source contract: a valid sample is presented every cycle, starting one cycle after its enable is high. The finished flag is high with the last sample.
- IDLE: on start=1 clear error, go to LOAD_COEFF, assert coeffEnable.
- LOAD_COEFF:
  - Each cycle after the first, register the coeff sample.
  - Pulse mfCoeffLoad one cycle later, with mfCoeffIndex equal to the sample count (0..COEFF_LENGTH-1).
  - On coeffFinishedFlag: deassert coeffEnable and go to GAP. If count+1 != COEFF_LENGTH, set error.
  - If count reaches COEFF_LENGTH without the flag: set error, deassert the enable, go to GAP.
- GAP: outputs idle for GAP_CYCLES cycles, then go to STREAM_DATA and assert dataEnable.
- STREAM_DATA: same rules as LOAD_COEFF, using mfDataValid and DATA_LENGTH; no index output. Exit to FLUSH.
- FLUSH: count FLUSH_CYCLES, then go to DONE.
- DONE: pulse done for one cycle, return to IDLE.
- Latency from source sample to mf* output: exactly 1 cycle. Output samples pass through unmodified; no arithmetic.
- start while busy is ignored. start held high continuously re-runs after each DONE→IDLE, with one idle cycle between runs.
- A finished flag arriving on the same cycle as the count terminal is not an error.
- Counters are sized $clog2(max(COEFF_LENGTH, DATA_LENGTH))+1 and do not wrap in normal operation.

Optional Feature:
- Macro: MF_LOAD_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in LOAD_COEFF and STREAM_DATA.
  - If a state exceeds its LENGTH+8 cycles without a finished flag, set error, drop both enables and go straight to IDLE. No done pulse is issued.
  - An extra output port, timeout (1 bit, sticky, cleared on the next start), is also set.
- Undefined: no watchdog and no timeout port. The count-terminal exit alone bounds each state.

Decomposition:
- Package mf_pkg holds:
  - the state enum (IDLE, LOAD_COEFF, GAP, STREAM_DATA, FLUSH, DONE);
  - the default DATA_WIDTH;
  - the state encoding width.
- One natural sub-module, mf_stream_forwarder, instantiated twice (coeff and data). It holds the enable, the 1-cycle sample register, the sample counter, the terminal/flag detection and the mismatch output. The top holds the FSM, the gap/flush counters and done.

Test Plan:
- Nominal: COEFF_LENGTH=8, DATA_LENGTH=20, ideal sources, start pulse → 8 mfCoeffLoad pulses with indices 0..7, 4 idle cycles, 20 mfDataValid pulses, done one cycle after 16 flush cycles, error=0.
- Early flag: coeff source raises its flag on sample 5 of 8 → coeffEnable drops, error=1, run still completes with done.
- Missing flag: data source never flags → stop after 20 samples, error=1. With MF_LOAD_TIMEOUT_EN and the flag plus enable stalled, timeout=1 at cycle 28 of STREAM_DATA and the block returns to IDLE.
- Reset mid-stream: assert reset at data sample 10 → all outputs 0 in the same cycle, IDLE. A new start runs cleanly with error=0.
- start asserted during STREAM_DATA → ignored, sample count unchanged. start held high → back-to-back runs with one IDLE cycle between.
- Data integrity: sources emit ramp Re=i, Im=-i → mf outputs match the ramp, delayed exactly 1 cycle.
